// File: rtl/ccip_host_mem_responder.sv
// ccip_host_mem_responder: stands in for host memory on the FIU side of an AFU.
// Read requests (c0) and write requests (c1) are queued in independent FIFOs,
// serviced from a line-addressed memory, and answered with the request mdata.

// Request FIFO with registered almost-full and a combinational drop strobe.
module ccip_req_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int SLACK = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         pop_en,
    output logic         pop,
    output logic [W-1:0] head,
    output logic         alm_full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] ent [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, cnt_nxt;
    logic          empty, full, push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop     = !reset && pop_en && !empty;
    assign push    = !reset && in_valid && (!full || pop);
    assign drop    = !reset && in_valid && full && !pop;
    assign cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
    assign head    = ent[rp];

    // Pointers, occupancy and almost-full track the post-edge count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            alm_full <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            cnt      <= cnt_nxt;
            alm_full <= (cnt_nxt >= (AW+1)'(DEPTH - SLACK));
        end
    end

    // Entry storage needs no reset; pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) ent[wp] <= in_data;
    end
endmodule

module ccip_host_mem_responder #(
    parameter int DEPTH          = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALM_FULL_SLACK = 2,
    parameter int RD_LATENCY     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [511:0] c1_req_data,
    input  logic         throttle,
    output logic         c0_alm_full,
    output logic         c1_alm_full,
    output logic         c0_rsp_valid,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic         overflow,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [15:0]   mdata;
    } rd_req_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [15:0]   mdata;
        logic [511:0]  data;
    } wr_req_t;

    rd_req_t c0_in, c0_head;
    wr_req_t c1_in, c1_head;
    logic    c0_pop, c1_pop, c0_drop, c1_drop;

    // Only the line index is kept; upper address bits wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c0_req_addr[41:IW], c1_req_addr[41:IW]};

    assign c0_in = '{idx: c0_req_addr[IW-1:0], mdata: c0_req_mdata};
    assign c1_in = '{idx: c1_req_addr[IW-1:0], mdata: c1_req_mdata, data: c1_req_data};

    ccip_req_fifo #(.W($bits(rd_req_t)), .DEPTH(FIFO_DEPTH), .SLACK(ALM_FULL_SLACK)) u_c0_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (c0_req_valid),
        .in_data  (c0_in),
        .pop_en   (!throttle),
        .pop      (c0_pop),
        .head     (c0_head),
        .alm_full (c0_alm_full),
        .drop     (c0_drop)
    );

    ccip_req_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH), .SLACK(ALM_FULL_SLACK)) u_c1_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (c1_req_valid),
        .in_data  (c1_in),
        .pop_en   (!throttle),
        .pop      (c1_pop),
        .head     (c1_head),
        .alm_full (c1_alm_full),
        .drop     (c1_drop)
    );

    logic [511:0] mem [DEPTH];

    logic [RD_LATENCY:0]             vld_pipe;
    logic [RD_LATENCY-1:0][511:0]    dat_pipe;
    logic [RD_LATENCY-1:0][15:0]     md_pipe;
    logic                            wr_vld_q;
    logic [15:0]                     wr_md_q;

    assign c0_rsp_valid = vld_pipe[RD_LATENCY];

    // Memory port: read-first, so a same-index write pop in this cycle is not seen.
    always_ff @(posedge clk) begin
        if (c1_pop) mem[c1_head.idx] <= c1_head.data;
        if (c0_pop) begin
            dat_pipe[0] <= mem[c0_head.idx];
            md_pipe[0]  <= c0_head.mdata;
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
            dat_pipe[k] <= dat_pipe[k-1];
            md_pipe[k]  <= md_pipe[k-1];
        end
    end

    // Read response valid shift register and held output payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe     <= '0;
            c0_rsp_data  <= '0;
            c0_rsp_mdata <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], c0_pop};
            if (vld_pipe[RD_LATENCY-1]) begin
                c0_rsp_data  <= dat_pipe[RD_LATENCY-1];
                c0_rsp_mdata <= md_pipe[RD_LATENCY-1];
            end
        end
    end

    // Write acknowledge goes out the cycle after the memory update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld_q     <= 1'b0;
            wr_md_q      <= '0;
            c1_rsp_valid <= 1'b0;
            c1_rsp_mdata <= '0;
        end else begin
            wr_vld_q     <= c1_pop;
            if (c1_pop) wr_md_q <= c1_head.mdata;
            c1_rsp_valid <= wr_vld_q;
            if (wr_vld_q) c1_rsp_mdata <= wr_md_q;
        end
    end

    // Response counters advance with the edge that raises each response valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_count <= rd_count + 32'(vld_pipe[RD_LATENCY-1]);
            wr_count <= wr_count + 32'(wr_vld_q);
        end
    end

    // Sticky flag for any request dropped at a full FIFO.
    always_ff @(posedge clk) begin
        if (reset)                  overflow <= 1'b0;
        else if (c0_drop | c1_drop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Randomized scoreboard bench for ccip_host_mem_responder. The driver keeps a
// queue-level model of both request channels and the memory; the monitor
// compares DUT responses and flags against what the model predicted.
module tb_ccip_host_mem_responder;
    localparam int DEPTH = 64;
    localparam int FD    = 8;
    localparam int SLACK = 2;
    localparam int RDL   = 2;

    logic         clk, reset;
    logic         c0_req_valid, c1_req_valid, throttle;
    logic [41:0]  c0_req_addr, c1_req_addr;
    logic [15:0]  c0_req_mdata, c1_req_mdata;
    logic [511:0] c1_req_data;
    logic         c0_alm_full, c1_alm_full, c0_rsp_valid, c1_rsp_valid, overflow;
    logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic [31:0]  rd_count, wr_count;

    ccip_host_mem_responder #(
        .DEPTH(DEPTH), .FIFO_DEPTH(FD), .ALM_FULL_SLACK(SLACK), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
        .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
        .c1_req_data(c1_req_data), .throttle(throttle),
        .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
        .overflow(overflow), .rd_count(rd_count), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; logic [15:0] md; logic [511:0] d; } rexp_t;
    typedef struct { int cyc; logic [15:0] md; } wexp_t;
    typedef struct { int cyc; bit rst; bit a0; bit a1; bit ovf; bit chk_empty; } flg_t;
    typedef struct { logic [5:0] idx; logic [15:0] md; logic [511:0] d; } mreq_t;

    rexp_t        exp_rd[$];
    wexp_t        exp_wr[$];
    flg_t         flg_q[$];
    mreq_t        mq0[$], mq1[$];
    logic [511:0] mm [DEPTH];
    bit           m_ovf;
    int           cyc;
    int           total, bad;
    int           seen_rd, seen_wr;

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    // One clock: drive, then advance the model at the edge, then queue flags.
    task automatic step(input bit rv, input logic [41:0] ra, input logic [15:0] rm,
                        input bit wv, input logic [41:0] wa, input logic [15:0] wm,
                        input logic [511:0] wd, input bit thr, input bit rst, input bit ce);
        mreq_t r, w;
        flg_t  f;
        c0_req_valid = rv; c0_req_addr = ra; c0_req_mdata = rm;
        c1_req_valid = wv; c1_req_addr = wa; c1_req_mdata = wm; c1_req_data = wd;
        throttle = thr; reset = rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq0.delete(); mq1.delete(); exp_rd.delete(); exp_wr.delete();
            m_ovf = 1'b0;
        end else begin
            if (!thr && mq0.size() > 0) begin
                r = mq0.pop_front();
                exp_rd.push_back('{cyc + RDL, r.md, mm[r.idx]});
            end
            if (!thr && mq1.size() > 0) begin
                w = mq1.pop_front();
                mm[w.idx] = w.d;
                exp_wr.push_back('{cyc + 1, w.md});
            end
            if (rv) begin
                if (mq0.size() < FD) mq0.push_back('{ra[5:0], rm, '0});
                else m_ovf = 1'b1;
            end
            if (wv) begin
                if (mq1.size() < FD) mq1.push_back('{wa[5:0], wm, wd});
                else m_ovf = 1'b1;
            end
        end
        f.cyc = cyc; f.rst = rst; f.ovf = m_ovf; f.chk_empty = ce;
        f.a0 = (mq0.size() >= FD - SLACK);
        f.a1 = (mq1.size() >= FD - SLACK);
        flg_q.push_back(f);
        @(negedge clk);
    endtask

    task automatic rd(input logic [41:0] a, input logic [15:0] m, input bit thr);
        step(1'b1, a, m, 1'b0, '0, '0, '0, thr, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
        step(1'b0, '0, '0, 1'b1, a, m, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_cyc();
        step(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: consumes one flag record per cycle and checks DUT outputs.
    always @(negedge clk) begin
        flg_t  f;
        rexp_t r;
        wexp_t w;
        if (flg_q.size() != 0) begin
            f = flg_q.pop_front();
            if (f.rst) begin
                seen_rd = 0;
                seen_wr = 0;
                chk("rst_c0_valid", c0_rsp_valid, 0);
                chk("rst_c1_valid", c1_rsp_valid, 0);
                chk("rst_c0_data", c0_rsp_data, 0);
                chk("rst_c0_mdata", c0_rsp_mdata, 0);
                chk("rst_c1_mdata", c1_rsp_mdata, 0);
            end
            if (c0_rsp_valid) begin
                seen_rd++;
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL c0_unexpected_rsp cycle=%0d mdata=%0h expected no response", f.cyc, c0_rsp_mdata);
                end else begin
                    r = exp_rd.pop_front();
                    chk("c0_latency_cycle", f.cyc, r.cyc);
                    chk("c0_mdata", c0_rsp_mdata, r.md);
                    chk("c0_data", c0_rsp_data, r.d);
                end
            end
            if (c1_rsp_valid) begin
                seen_wr++;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL c1_unexpected_rsp cycle=%0d mdata=%0h expected no response", f.cyc, c1_rsp_mdata);
                end else begin
                    w = exp_wr.pop_front();
                    chk("c1_latency_cycle", f.cyc, w.cyc);
                    chk("c1_mdata", c1_rsp_mdata, w.md);
                end
            end
            chk("rd_count", rd_count, seen_rd);
            chk("wr_count", wr_count, seen_wr);
            chk("c0_alm_full", c0_alm_full, f.a0);
            chk("c1_alm_full", c1_alm_full, f.a1);
            chk("overflow", overflow, f.ovf);
            if (f.chk_empty) begin
                chk("drain_rd_pending", exp_rd.size(), 0);
                chk("drain_wr_pending", exp_wr.size(), 0);
            end
        end
    end

    initial begin
        logic [41:0]  ra, wa;
        logic [511:0] d;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        c0_req_valid = 0; c1_req_valid = 0; throttle = 0; reset = 1;
        c0_req_addr = '0; c1_req_addr = '0; c0_req_mdata = '0; c1_req_mdata = '0; c1_req_data = '0;
        rst_cyc(); rst_cyc();

        // Give every line a known value.
        for (int i = 0; i < DEPTH; i++) begin
            wa = 42'({$urandom(), $urandom()});
            wa[5:0] = 6'(i);
            wr(wa, 16'(i), rand512());
        end
        idle(4);

        // Basic write then read of line 5.
        d = '0; d[23:8] = 16'h2D1E;
        wr(42'h5, 16'h11, d); idle(3);
        rd(42'h5, 16'h22, 1'b0); idle(4);

        // Address wrap: 0x45 aliases line 5.
        wr(42'h45, 16'h33, rand512()); idle(3);
        rd(42'h05, 16'h34, 1'b0); idle(4);

        // Throttled fill: almost-full at 6, overflow on the 9th, 8 answers.
        rst_cyc();
        for (int i = 0; i < 9; i++) rd(42'(i), 16'(16'h100 + i), 1'b1);
        idle(14);

        // Same-cycle read and write pop to line 3.
        d = '0; d[7:0] = 8'hAA;
        wr(42'h3, 16'h40, d); idle(3);
        d = '0; d[7:0] = 8'hBB;
        step(1'b1, 42'h3, 16'h41, 1'b1, 42'h3, 16'h42, d, 1'b0, 1'b0, 1'b0);
        idle(3);
        rd(42'h3, 16'h43, 1'b0); idle(4);

        // Sixteen back-to-back reads.
        for (int i = 0; i < 16; i++) rd(42'($urandom()), 16'(16'h200 + i), 1'b0);
        idle(5);

        // Reset with reads in flight; memory survives.
        for (int i = 0; i < 3; i++) rd(42'(i + 10), 16'(16'h300 + i), 1'b0);
        rst_cyc();
        idle(6);
        rd(42'h5, 16'h310, 1'b0); idle(4);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            ra = 42'({$urandom(), $urandom()});
            wa = 42'({$urandom(), $urandom()});
            step(bit'($urandom_range(0, 1)), ra, 16'($urandom()),
                 bit'($urandom_range(0, 1)), wa, 16'($urandom()), rand512(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0), 1'b0);
        end

        idle(20);
        step(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
